// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared constants for the interrupt front-end:
//   - default source count / index width
//   - FSM state encoding, also driven out on the controller's DbgState port
// The two nested-NMI states exist only when IRQ_NMI_NEST_EN is defined.
// -----------------------------------------------------------------------------
package irq_pkg;

    localparam int NUM_IRQ_DEF = 8;
    localparam int IDX_W_DEF   = 3;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] irqState_t;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_REQ     = 3'd1;
    localparam logic [STATE_W-1:0] ST_SERVICE = 3'd2;
`ifdef IRQ_NMI_NEST_EN
    localparam logic [STATE_W-1:0] ST_NMI_REQ = 3'd3;
    localparam logic [STATE_W-1:0] ST_NMI_SVC = 3'd4;
`endif

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational fixed-priority encoder, lowest set index wins.
// Ports:
//   req   in  NUM_IRQ  request vector
//   valid out 1        any request bit set
//   idx   out IDX_W    index of the lowest set bit (0 when none)
// -----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// irq_priority_ctrl
// Interrupt front-end for the multicycle MIPS Controller: NUM_IRQ maskable
// edge-triggered sources plus one NMI, fixed priority (NMI, then lowest
// index), one request presented to the Controller at a time, and tracking of
// the in-service interrupt until Eret.
//
// Optional build macro: IRQ_NMI_NEST_EN -- allows one NMI to nest inside a
// maskable handler; the interrupted IrqId is restored on the NMI's Eret.
//
// Ports:
//   Clk            in   1        clock, rising edge
//   Rst_n          in   1        asynchronous active-low reset
//   INT            in   NUM_IRQ  maskable requests (rising edge -> Pending)
//   NMI            in   1        non-maskable request (rising edge -> pending)
//   INTD           in   1        global maskable disable from Controller
//   MaskWr         in   1        load MaskData into the mask register
//   MaskData       in   NUM_IRQ  new mask, 1 = masked
//   INA            in   1        interrupt acknowledge from Controller
//   Eret           in   1        handler return from Controller
//   isInterrupted  out  1        request to Controller
//   IrqId          out  IDX_W    requested / in-service source index
//   IsNmi          out  1        request / service is the NMI
//   InService      out  1        a handler is active
//   Pending        out  NUM_IRQ  pending-bit register
//   DbgState       out  STATE_W  current FSM state (irq_pkg encoding)
//
// Handshake: isInterrupted is the valid; INA is the ready. The request holds
// IrqId/IsNmi stable from the cycle isInterrupted rises until the clock edge
// where INA is sampled high. A maskable request may be withdrawn (valid drops
// without INA) if the source stops being eligible; an NMI request never is.
// -----------------------------------------------------------------------------
module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [NUM_IRQ-1:0] INT,
    input  logic               NMI,
    input  logic               INTD,
    input  logic               MaskWr,
    input  logic [NUM_IRQ-1:0] MaskData,
    input  logic               INA,
    input  logic               Eret,
    output logic               isInterrupted,
    output logic [IDX_W-1:0]   IrqId,
    output logic               IsNmi,
    output logic               InService,
    output logic [NUM_IRQ-1:0] Pending,
    output logic [STATE_W-1:0] DbgState
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] stateNext;

    logic [NUM_IRQ-1:0] intPrev;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] intRise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] pendClr;
    logic               nmiPrev;
    logic               nmiPend;
    logic               nmiRise;
    logic               nmiClr;

    logic               encValid;
    logic [IDX_W-1:0]   encIdx;
    logic [IDX_W-1:0]   idNext;
    logic               isNmiNext;

`ifdef IRQ_NMI_NEST_EN
    logic [IDX_W-1:0]   savedId;
    logic [IDX_W-1:0]   savedIdNext;
`endif

    // History registers reset to 0, so an input already high when reset
    // releases is seen as a rising edge on the first clock.
    assign intRise  = INT & ~intPrev;
    assign nmiRise  = NMI & ~nmiPrev;
    assign eligible = Pending & ~mask & {NUM_IRQ{~INTD}};

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_enc (
        .req   (eligible),
        .valid (encValid),
        .idx   (encIdx)
    );

    always_comb begin
        stateNext = state;
        idNext    = IrqId;
        isNmiNext = IsNmi;
        pendClr   = '0;
        nmiClr    = 1'b0;
`ifdef IRQ_NMI_NEST_EN
        savedIdNext = savedId;
`endif
        case (state)
            ST_IDLE: begin
                if (nmiPend) begin
                    stateNext = ST_REQ;
                    isNmiNext = 1'b1;
                    idNext    = '0;
                end else if (encValid) begin
                    stateNext = ST_REQ;
                    isNmiNext = 1'b0;
                    idNext    = encIdx;
                end
            end
            ST_REQ: begin
                // Target is frozen here; a late NMI waits for the next IDLE.
                if (INA) begin
                    stateNext = ST_SERVICE;
                    if (IsNmi) begin
                        nmiClr = 1'b1;
                    end else begin
                        pendClr[IrqId] = 1'b1;
                    end
                end else if (!IsNmi && !eligible[IrqId]) begin
                    stateNext = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (Eret) begin
                    stateNext = ST_IDLE;
`ifdef IRQ_NMI_NEST_EN
                end else if (!IsNmi && nmiPend) begin
                    // Nested NMI: remember the maskable handler's id.
                    stateNext   = ST_NMI_REQ;
                    savedIdNext = IrqId;
                    isNmiNext   = 1'b1;
                    idNext      = '0;
`endif
                end
            end
`ifdef IRQ_NMI_NEST_EN
            // The maskable handler is suspended here, so its Eret cannot
            // arrive; Eret is only meaningful once the NMI is being served.
            ST_NMI_REQ: begin
                if (INA) begin
                    stateNext = ST_NMI_SVC;
                    nmiClr    = 1'b1;
                end
            end
            ST_NMI_SVC: begin
                if (Eret) begin
                    stateNext = ST_SERVICE;
                    isNmiNext = 1'b0;
                    idNext    = savedId;
                end
            end
`endif
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= ST_IDLE;
            IrqId   <= '0;
            IsNmi   <= 1'b0;
            Pending <= '0;
            mask    <= '0;
            intPrev <= '0;
            nmiPrev <= 1'b0;
            nmiPend <= 1'b0;
`ifdef IRQ_NMI_NEST_EN
            savedId <= '0;
`endif
        end else begin
            state   <= stateNext;
            IrqId   <= idNext;
            IsNmi   <= isNmiNext;
            intPrev <= INT;
            nmiPrev <= NMI;
            if (MaskWr) begin
                mask <= MaskData;
            end
            // Clear first, then set: a new edge beats a same-cycle INA clear.
            Pending <= (Pending & ~pendClr) | intRise;
            nmiPend <= (nmiPend & ~nmiClr) | nmiRise;
`ifdef IRQ_NMI_NEST_EN
            savedId <= savedIdNext;
`endif
        end
    end

`ifdef IRQ_NMI_NEST_EN
    assign isInterrupted = (state == ST_REQ) || (state == ST_NMI_REQ);
    assign InService     = (state == ST_SERVICE) || (state == ST_NMI_REQ) ||
                           (state == ST_NMI_SVC);
`else
    assign isInterrupted = (state == ST_REQ);
    assign InService     = (state == ST_SERVICE);
`endif

    assign DbgState = state;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
module tb_irq_priority_ctrl;
    import irq_pkg::*;

    localparam int N       = 8;
    localparam int IW      = 3;
    localparam int EXP_W   = 14;
    localparam int N_RAND  = 3000;

    // ---------------- clock / reset ----------------
    logic         Clk = 1'b0;
    logic         Rst_n;
    logic [N-1:0] INT;
    logic         NMI;
    logic         INTD;
    logic         MaskWr;
    logic [N-1:0] MaskData;
    logic         INA;
    logic         Eret;
    logic         isInterrupted;
    logic [IW-1:0] IrqId;
    logic         IsNmi;
    logic         InService;
    logic [N-1:0] Pending;
    logic [STATE_W-1:0] dbgState;

    always #5 Clk = ~Clk;

    irq_priority_ctrl #(.NUM_IRQ(N), .IDX_W(IW)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .INT           (INT),
        .NMI           (NMI),
        .INTD          (INTD),
        .MaskWr        (MaskWr),
        .MaskData      (MaskData),
        .INA           (INA),
        .Eret          (Eret),
        .isInterrupted (isInterrupted),
        .IrqId         (IrqId),
        .IsNmi         (IsNmi),
        .InService     (InService),
        .Pending       (Pending),
        .DbgState      (dbgState)
    );

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic clearInputs();
        INT = '0; NMI = 1'b0; INTD = 1'b0; MaskWr = 1'b0;
        MaskData = '0; INA = 1'b0; Eret = 1'b0;
    endtask

    task automatic doReset();
        Rst_n = 1'b0;
        clearInputs();
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic pulseIna();
        INA = 1'b1; tick(); INA = 1'b0;
    endtask

    task automatic pulseEret();
        Eret = 1'b1; tick(); Eret = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 nothing happening, 1 request offered, 2 handler running.
    // A nested NMI is tracked by separate flags on top of phase 2.
    bit [N-1:0] mPend, mMask, mPrev;
    bit         mPrevNmi, mNmiPend;
    int         mPhase;
    bit         mNmi;
    int         mId;
    bit         mNestReq, mNestSvc;

    function automatic int lowestSet(input bit [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic modelReset();
        mPend = '0; mMask = '0; mPrev = '0; mPrevNmi = 0; mNmiPend = 0;
        mPhase = 0; mNmi = 0; mId = 0; mNestReq = 0; mNestSvc = 0;
    endtask

    task automatic modelStep();
        bit [N-1:0] rise, elig, clr;
        bit nrise, nclr;
        rise  = INT & ~mPrev;
        nrise = NMI & ~mPrevNmi;
        elig  = INTD ? '0 : (mPend & ~mMask);
        clr   = '0;
        nclr  = 0;
        if (mNestReq) begin
            if (INA) begin mNestReq = 0; mNestSvc = 1; nclr = 1; end
        end else if (mNestSvc) begin
            if (Eret) mNestSvc = 0;
        end else if (mPhase == 0) begin
            if (mNmiPend) begin mPhase = 1; mNmi = 1; mId = 0; end
            else if (elig != 0) begin mPhase = 1; mNmi = 0; mId = lowestSet(elig); end
        end else if (mPhase == 1) begin
            if (INA) begin
                mPhase = 2;
                if (mNmi) nclr = 1; else clr[mId] = 1'b1;
            end else if (!mNmi && !elig[mId]) begin
                mPhase = 0;
            end
        end else begin
            if (Eret) mPhase = 0;
`ifdef IRQ_NMI_NEST_EN
            else if (!mNmi && mNmiPend) mNestReq = 1;
`endif
        end
        mPend    = (mPend & ~clr) | rise;
        mNmiPend = (mNmiPend & ~nclr) | nrise;
        if (MaskWr) mMask = MaskData;
        mPrev    = INT;
        mPrevNmi = NMI;
    endtask

    function automatic logic [EXP_W-1:0] modelOut();
        logic       eInt, eSvc, eNmi;
        logic [2:0] eId;
        eInt = (mPhase == 1) || mNestReq;
        eSvc = (mPhase == 2);
        eNmi = (mNestReq || mNestSvc) ? 1'b1 : mNmi;
        eId  = (mNestReq || mNestSvc) ? 3'd0 : 3'(mId);
        return {eInt, eSvc, eNmi, eId, mPend};
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] expQ[$];

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]  intPat;
        logic [N-1:0]  mask;
        logic          intd;
        logic          expReq;
        logic [IW-1:0] expId;
        logic [N-1:0]  expPend;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [EXP_W-1:0] exp, act;

        vecs[0] = '{8'h20, 8'h00, 1'b0, 1'b1, 3'd5, 8'h20};
        vecs[1] = '{8'h44, 8'h00, 1'b0, 1'b1, 3'd2, 8'h44};
        vecs[2] = '{8'h04, 8'h04, 1'b0, 1'b0, 3'd0, 8'h04};
        vecs[3] = '{8'h81, 8'h01, 1'b0, 1'b1, 3'd7, 8'h81};
        vecs[4] = '{8'hFF, 8'h00, 1'b1, 1'b0, 3'd0, 8'hFF};
        vecs[5] = '{8'h01, 8'h00, 1'b0, 1'b1, 3'd0, 8'h01};
        vecs[6] = '{8'h80, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80};
        vecs[7] = '{8'h0C, 8'h04, 1'b0, 1'b1, 3'd3, 8'h0C};
        vecs[8] = '{8'h00, 8'hF0, 1'b0, 1'b0, 3'd0, 8'h00};

        Rst_n = 1'b0;
        clearInputs();

        // ---- reset state ----
        doReset();
        check("rst_isInterrupted", 32'(isInterrupted), 0);
        check("rst_IrqId", 32'(IrqId), 0);
        check("rst_IsNmi", 32'(IsNmi), 0);
        check("rst_InService", 32'(InService), 0);
        check("rst_Pending", 32'(Pending), 0);
        check("rst_state", 32'(dbgState), 32'(ST_IDLE));

        // ---- table-driven single-shot arbitration ----
        for (int v = 0; v < 9; v++) begin
            doReset();
            INTD = vecs[v].intd;
            MaskWr = 1'b1; MaskData = vecs[v].mask;
            tick();
            MaskWr = 1'b0;
            INT = vecs[v].intPat;
            tick();
            INT = '0;
            tick();
            check($sformatf("vec%0d_req", v), 32'(isInterrupted), 32'(vecs[v].expReq));
            check($sformatf("vec%0d_id", v), 32'(IrqId), 32'(vecs[v].expId));
            check($sformatf("vec%0d_pend", v), 32'(Pending), 32'(vecs[v].expPend));
            INTD = 1'b0;
        end

        // ---- seq 1: single source full handshake ----
        doReset();
        INT = 8'h20; tick();
        check("s1_pend_set", 32'(Pending), 32'h20);
        check("s1_no_req_yet", 32'(isInterrupted), 0);
        INT = '0; tick();
        check("s1_req", 32'(isInterrupted), 1);
        check("s1_id", 32'(IrqId), 5);
        pulseIna();
        check("s1_pend_clr", 32'(Pending), 0);
        check("s1_insvc", 32'(InService), 1);
        check("s1_req_drop", 32'(isInterrupted), 0);
        pulseEret();
        check("s1_svc_done", 32'(InService), 0);

        // ---- seq 2: simultaneous edges, lowest first, then the other ----
        doReset();
        INT = 8'h44; tick(); INT = '0; tick();
        check("s2_first", 32'(IrqId), 2);
        pulseIna();
        pulseEret();
        check("s2_idle_gap", 32'(isInterrupted), 0);
        tick();
        check("s2_second_req", 32'(isInterrupted), 1);
        check("s2_second_id", 32'(IrqId), 6);

        // ---- seq 3: masked source stays pending, unmask releases it ----
        doReset();
        MaskWr = 1'b1; MaskData = 8'h04; tick(); MaskWr = 1'b0;
        INT = 8'h04; tick(); INT = '0; tick();
        check("s3_pend", 32'(Pending), 32'h04);
        check("s3_blocked", 32'(isInterrupted), 0);
        MaskWr = 1'b1; MaskData = 8'h00; tick(); MaskWr = 1'b0;
        tick();
        check("s3_req", 32'(isInterrupted), 1);
        check("s3_id", 32'(IrqId), 2);

        // ---- seq 4: INTD withdraws a request, clearing it re-raises ----
        doReset();
        INT = 8'h08; tick(); INT = '0; tick();
        check("s4_req", 32'(isInterrupted), 1);
        INTD = 1'b1; tick();
        check("s4_withdrawn", 32'(isInterrupted), 0);
        check("s4_pend_kept", 32'(Pending[3]), 1);
        INTD = 1'b0; tick();
        check("s4_reraise", 32'(isInterrupted), 1);
        check("s4_reraise_id", 32'(IrqId), 3);

        // ---- seq 5a: NMI ignores INTD and beats a pending maskable ----
        doReset();
        INTD = 1'b1; INT = 8'h01; NMI = 1'b1; tick();
        INT = '0; NMI = 1'b0; tick();
        check("s5_nmi_req", 32'(isInterrupted), 1);
        check("s5_nmi_flag", 32'(IsNmi), 1);
        pulseIna();
        check("s5_nmi_svc", 32'(InService), 1);
        check("s5_int0_still_pend", 32'(Pending), 32'h01);
        pulseEret();
        INTD = 1'b0;

        // ---- seq 5b: NMI during maskable service of IrqId 4 ----
        doReset();
        INT = 8'h10; tick(); INT = '0; tick();
        pulseIna();
        check("s5b_svc_id", 32'(IrqId), 4);
        NMI = 1'b1; tick(); NMI = 1'b0; tick();
`ifdef IRQ_NMI_NEST_EN
        check("s5b_nest_req", 32'(isInterrupted), 1);
        check("s5b_nest_nmi", 32'(IsNmi), 1);
        check("s5b_nest_insvc", 32'(InService), 1);
        pulseIna();
        check("s5b_nest_ack", 32'(isInterrupted), 0);
        pulseEret();
        check("s5b_restore_id", 32'(IrqId), 4);
        check("s5b_restore_nmi", 32'(IsNmi), 0);
        check("s5b_restore_svc", 32'(InService), 1);
        pulseEret();
        check("s5b_done", 32'(InService), 0);
`else
        check("s5b_nmi_waits", 32'(isInterrupted), 0);
        check("s5b_still_svc", 32'(InService), 1);
        check("s5b_still_id", 32'(IrqId), 4);
        pulseEret();
        check("s5b_svc_done", 32'(InService), 0);
        tick();
        check("s5b_nmi_req", 32'(isInterrupted), 1);
        check("s5b_nmi_flag", 32'(IsNmi), 1);
`endif

        // ---- seq 6: async reset in SERVICE, release with INT[1] high ----
        doReset();
        INT = 8'h01; tick(); INT = '0; tick();
        pulseIna();
        check("s6_pre_svc", 32'(InService), 1);
        #2 Rst_n = 1'b0;
        #1;
        check("s6_async_insvc", 32'(InService), 0);
        check("s6_async_req", 32'(isInterrupted), 0);
        check("s6_async_id", 32'(IrqId), 0);
        INT = 8'h02;
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        check("s6_edge_at_release", 32'(Pending), 32'h02);
        INT = '0;

        // ---- randomized run against the reference model ----
        doReset();
        modelReset();
        for (int c = 0; c < N_RAND; c++) begin
            INT      = INT ^ N'($urandom & $urandom & $urandom);
            NMI      = ($urandom_range(0, 15) == 0) ? ~NMI : NMI;
            INTD     = ($urandom_range(0, 9) == 0);
            MaskWr   = ($urandom_range(0, 19) == 0);
            MaskData = N'($urandom & $urandom);
            INA      = ($urandom_range(0, 2) == 0);
            Eret     = ($urandom_range(0, 3) == 0);
            @(posedge Clk);
            modelStep();
            expQ.push_back(modelOut());
            @(negedge Clk);
            exp = expQ.pop_front();
            act = {isInterrupted, InService, IsNmi, IrqId, Pending};
            nTests++;
            if (act !== exp) begin
                nFail++;
                $display("FAIL rand_cycle%0d: got {req,svc,nmi,id,pend}=%0b,%0b,%0b,%0d,0x%0h expected %0b,%0b,%0b,%0d,0x%0h",
                         c, act[13], act[12], act[11], act[10:8], act[7:0],
                         exp[13], exp[12], exp[11], exp[10:8], exp[7:0]);
            end
        end
        clearInputs();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
